// File: rtl/bits2bytes_stream.sv
// -----------------------------------------------------------------------------
// bits2bytes_stream
//
// Packs a stream of d-bit symbols (d chosen per packet, 1..IN_W) LSB-first
// into a bit accumulator and emits OUT_BYTES-wide byte beats. When the last
// symbol of a packet has been accepted, the residue is flushed as a final
// beat, zero-padded to a byte boundary, with the number of valid bytes.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous reset, active-high
//   d_i           symbol width for the current packet (0 or >IN_W -> IN_W)
//   in_valid_i    input symbol valid
//   in_ready_o    input ready (registered state only)
//   in_data_i     symbol; bits above d are ignored
//   in_last_i     last symbol of packet
//   out_valid_o   output beat valid
//   out_ready_i   output ready
//   out_data_o    packed bytes, byte i = out_data_o[8i+:8]
//   out_nbytes_o  number of valid bytes in the beat
//   out_last_o    final beat of packet
// -----------------------------------------------------------------------------
module bits2bytes_stream #(
    parameter int IN_W      = 12,
    parameter int OUT_BYTES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [3:0]                     d_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [IN_W-1:0]                in_data_i,
    input  logic                           in_last_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [OUT_BYTES*8-1:0]         out_data_o,
    output logic [$clog2(OUT_BYTES+1)-1:0] out_nbytes_o,
    output logic                           out_last_o
);

    localparam int OUT_W = OUT_BYTES * 8;
    localparam int ACC_W = OUT_W + IN_W;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int NB_W  = $clog2(OUT_BYTES + 1);

    localparam logic [CNT_W:0]   ROOM_MAX = (CNT_W + 1)'(ACC_W);
    localparam logic [CNT_W-1:0] BEAT_BITS = CNT_W'(OUT_W);

    // Out-of-range widths fall back to the full symbol width.
    function automatic logic [CNT_W-1:0] eff_width(input logic [3:0] d);
        if (d == 4'd0 || int'(d) > IN_W) begin
            return CNT_W'(IN_W);
        end
        return CNT_W'(d);
    endfunction

    // Number of bytes needed to hold c bits.
    function automatic logic [NB_W-1:0] ceil_bytes(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] t;
        t = {1'b0, c} + (CNT_W + 1)'(7);
        return NB_W'(t >> 3);
    endfunction

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d;

    logic [CNT_W-1:0] d_eff;
    logic [CNT_W:0]   room_sum;
    logic             full_beat;
    logic             pop;
    logic             accept;
    logic [ACC_W-1:0] acc_pop;
    logic [CNT_W-1:0] cnt_pop;
    logic             flush_pop;
    logic [IN_W-1:0]  sym_mask;

    assign d_eff    = eff_width(d_i);
    assign room_sum = {1'b0, cnt_q} + {1'b0, d_eff};

    // Ready looks only at registered state, so a symbol is accepted only if it
    // fits even when no pop happens this cycle.
    assign in_ready_o = !flush_q && (room_sum <= ROOM_MAX);

    assign full_beat    = (cnt_q >= BEAT_BITS);
    assign out_valid_o  = full_beat || (flush_q && cnt_q != '0);
    assign out_data_o   = acc_q[OUT_W-1:0];
    assign out_nbytes_o = !out_valid_o ? '0 :
                          full_beat    ? NB_W'(OUT_BYTES) : ceil_bytes(cnt_q);
    // A full beat ends the packet only when it drains the accumulator exactly;
    // a partial beat can only exist while flushing.
    assign out_last_o   = flush_q && (full_beat ? (cnt_q == BEAT_BITS) : (cnt_q != '0));

    assign pop    = out_valid_o && out_ready_i;
    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        acc_pop   = acc_q;
        cnt_pop   = cnt_q;
        flush_pop = flush_q;

        // Pop first; a non-last pop is always a full beat.
        if (pop) begin
            if (out_last_o) begin
                acc_pop   = '0;
                cnt_pop   = '0;
                flush_pop = 1'b0;
            end else begin
                acc_pop = acc_q >> OUT_W;
                cnt_pop = cnt_q - BEAT_BITS;
            end
        end

        sym_mask = {IN_W{1'b1}} >> (CNT_W'(IN_W) - d_eff);

        acc_d   = acc_pop;
        cnt_d   = cnt_pop;
        flush_d = flush_pop;

        // Append at the post-pop fill level so a pop and accept can share a cycle.
        if (accept) begin
            acc_d = acc_pop | (ACC_W'(in_data_i & sym_mask) << cnt_pop);
            cnt_d = cnt_pop + d_eff;
            if (in_last_i) begin
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

endmodule
